// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner and the BCD entry front end.
// Logical key codes, frame classifier codes, sign nibbles and FSM states.
// Position-to-key mapping follows the physical DE10-Lite 4x4 keypad legend.
package keypad_pkg;

    // Logical key codes (digit keys carry their own value)
    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Frame codes: bit 4 clear means a single key whose code is in [3:0]
    localparam logic [4:0] FRAME_NONE  = 5'h10;
    localparam logic [4:0] FRAME_MULTI = 5'h11;

    localparam logic [3:0] SIGN_POS = 4'h0;
    localparam logic [3:0] SIGN_NEG = 4'h1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } key_state_e;

    // Physical position (row*4 + col) to logical key code
    function automatic logic [3:0] pos_to_key(input logic [3:0] pos);
        case (pos)
            4'd0:    return KEY_1;
            4'd1:    return KEY_2;
            4'd2:    return KEY_3;
            4'd3:    return KEY_A;
            4'd4:    return KEY_4;
            4'd5:    return KEY_5;
            4'd6:    return KEY_6;
            4'd7:    return KEY_B;
            4'd8:    return KEY_7;
            4'd9:    return KEY_8;
            4'd10:   return KEY_9;
            4'd11:   return KEY_C;
            4'd12:   return KEY_STAR;
            4'd13:   return KEY_0;
            4'd14:   return KEY_HASH;
            default: return KEY_D;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scan, row sync, frame classify, debounce and press/release FSM.
// press_o is combinational: high for the cycle after a single key becomes stable.
// No backpressure; one press per full release, MULTI frames never press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows_i,
    output logic [3:0] cols_o,
    output logic [3:0] key_code_o,
    output logic       press_o
);

    localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DBW = $clog2(DEBOUNCE + 1);

    logic [DW-1:0]  div_q;
    logic [1:0]     col_q;
    logic [3:0]     rows_s1_q, rows_s2_q;
    logic [15:0]    acc_q, frame_all;
    logic [4:0]     frame_code, cand_q, stable_q;
    logic [DBW-1:0] cnt_q, cnt_next;
    logic           slot_end, frame_end;
    key_state_e     state_q, state_d;

    assign slot_end   = (div_q == DW'(SCAN_DIV - 1));
    assign frame_end  = slot_end && (col_q == 2'd3);
    assign cols_o     = ~(4'b0001 << col_q);
    assign key_code_o = stable_q[3:0];

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_s1_q <= 4'hF;
            rows_s2_q <= 4'hF;
        end else begin
            rows_s1_q <= rows_i;
            rows_s2_q <= rows_s1_q;
        end
    end

    // Column slot timer and column index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            col_q <= 2'd0;
        end else if (slot_end) begin
            div_q <= '0;
            col_q <= col_q + 2'd1;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // Merge the current column's closed rows into the frame picture
    always_comb begin
        frame_all = acc_q;
        for (int r = 0; r < 4; r++) begin
            if (!rows_s2_q[r]) frame_all[r*4 + int'(col_q)] = 1'b1;
        end
    end

    // Frame accumulator, emptied after the last column is sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         acc_q <= '0;
        else if (frame_end) acc_q <= '0;
        else if (slot_end)  acc_q <= frame_all;
    end

    // Classify the completed frame as NONE, MULTI or one key
    always_comb begin
        logic [4:0] hits;
        logic [3:0] pos;
        hits = '0;
        pos  = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_all[i]) begin
                hits = hits + 5'd1;
                pos  = 4'(i);
            end
        end
        if (hits == 5'd0)      frame_code = FRAME_NONE;
        else if (hits == 5'd1) frame_code = {1'b0, pos_to_key(pos)};
        else                   frame_code = FRAME_MULTI;
    end

    // Consecutive-frame counter, saturating at DEBOUNCE
    always_comb begin
        if (frame_code != cand_q)               cnt_next = DBW'(1);
        else if (cnt_q >= DBW'(DEBOUNCE))       cnt_next = cnt_q;
        else                                    cnt_next = cnt_q + DBW'(1);
    end

    // Debounce: accept a frame code only after DEBOUNCE identical frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q   <= FRAME_NONE;
            cnt_q    <= '0;
            stable_q <= FRAME_NONE;
        end else if (frame_end) begin
            cand_q <= frame_code;
            cnt_q  <= cnt_next;
            if (cnt_next >= DBW'(DEBOUNCE)) stable_q <= frame_code;
        end
    end

    // Key FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Key FSM: press on first stable single key, re-arm only on NONE
    always_comb begin
        state_d = state_q;
        press_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!stable_q[4]) begin
                    press_o = 1'b1;
                    state_d = ST_PRESSED;
                end
            end
            default: begin
                if (stable_q == FRAME_NONE) state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/keypad_bcd_entry.sv
// Keypad front end building a signed three-digit BCD entry word.
// BCD, KEY_STROBE and VALID update on the edge after the scanner's press.
// No backpressure: every accepted press is applied immediately.
module keypad_bcd_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 20
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [3:0]  ROWS,
    output logic [3:0]  COLS,
    output logic [15:0] BCD,
    output logic        VALID,
    output logic        KEY_STROBE
);

    logic [3:0] key_code;
    logic       press;

    logic [3:0] sign_q, hund_q, tens_q, unit_q;
    logic [3:0] sign_d, hund_d, tens_d, unit_d;
    logic [1:0] n_q, n_d;
    logic       done_q, done_d;
    logic       valid_q, valid_d;
    logic       strobe_q;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scanner (
        .clk        (CLK),
        .rst_n      (CLR),
        .rows_i     (ROWS),
        .cols_o     (COLS),
        .key_code_o (key_code),
        .press_o    (press)
    );

    assign BCD        = {sign_q, hund_q, tens_q, unit_q};
    assign VALID      = valid_q;
    assign KEY_STROBE = strobe_q;

    // Action decoder: edit the entry according to the pressed key
    always_comb begin
        sign_d  = sign_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        unit_d  = unit_q;
        n_d     = n_q;
        done_d  = done_q;
        valid_d = 1'b0;
        if (press) begin
            if (key_code <= KEY_9) begin
                // A digit after enter starts a fresh entry
                if (done_q) begin
                    sign_d = SIGN_POS;
                    hund_d = 4'h0;
                    tens_d = 4'h0;
                    unit_d = 4'h0;
                    n_d    = 2'd0;
                    done_d = 1'b0;
                end
                if (n_d != 2'd3) begin
                    hund_d = tens_d;
                    tens_d = unit_d;
                    unit_d = key_code;
                    n_d    = n_d + 2'd1;
                end
            end else begin
                case (key_code)
                    KEY_A: begin
                        sign_d = (sign_q == SIGN_POS) ? SIGN_NEG : SIGN_POS;
                        done_d = 1'b0;
                    end
                    KEY_C: begin
                        sign_d = SIGN_POS;
                        hund_d = 4'h0;
                        tens_d = 4'h0;
                        unit_d = 4'h0;
                        n_d    = 2'd0;
                        done_d = 1'b0;
                    end
                    KEY_STAR: begin
                        if (n_q != 2'd0) begin
                            unit_d = tens_q;
                            tens_d = hund_q;
                            hund_d = 4'h0;
                            n_d    = n_q - 2'd1;
                        end
                    end
                    KEY_HASH: begin
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Entry register, digit count, enter flag and output strobes
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sign_q   <= SIGN_POS;
            hund_q   <= 4'h0;
            tens_q   <= 4'h0;
            unit_q   <= 4'h0;
            n_q      <= 2'd0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            hund_q   <= hund_d;
            tens_q   <= tens_d;
            unit_q   <= unit_d;
            n_q      <= n_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            strobe_q <= press;
        end
    end

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed bench for keypad_bcd_entry with a behavioural keypad matrix.
// Each press holds for 5 frames and releases for 5 frames (frame = 16 cycles).
// Strobe/valid pulses are counted on the falling clock edge.
module tb_keypad_bcd_entry;

    localparam int SD    = 4;
    localparam int DB    = 3;
    localparam int FRAME = 4 * SD;

    // Physical key positions (row*4 + col)
    localparam int P_1 = 0,  P_2 = 1,  P_3 = 2,  P_A = 3;
    localparam int P_4 = 4,  P_5 = 5,  P_6 = 6,  P_B = 7;
    localparam int P_7 = 8,  P_8 = 9,  P_9 = 10, P_C = 11;
    localparam int P_S = 12, P_0 = 13, P_H = 14, P_D = 15;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic [3:0]  ROWS;
    logic [3:0]  COLS;
    logic [15:0] BCD;
    logic        VALID;
    logic        KEY_STROBE;
    logic [15:0] keys_down = 16'h0;

    int strobe_cnt = 0;
    int valid_cnt  = 0;
    logic [15:0] valid_bcd = 16'hxxxx;
    int chk_cnt  = 0;
    int pass_cnt = 0;

    keypad_bcd_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .ROWS       (ROWS),
        .COLS       (COLS),
        .BCD        (BCD),
        .VALID      (VALID),
        .KEY_STROBE (KEY_STROBE)
    );

    always #5 CLK = ~CLK;

    // Keypad matrix: a closed key pulls its row low while its column is driven
    always_comb begin
        ROWS = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_down[r*4+c] && !COLS[c]) ROWS[r] = 1'b0;
    end

    // Pulse counters, sampled mid-cycle
    always @(negedge CLK) begin
        if (KEY_STROBE === 1'b1) strobe_cnt++;
        if (VALID === 1'b1) begin
            valid_cnt++;
            valid_bcd = BCD;
        end
    end

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(posedge CLK);
        #1;
    endtask

    task automatic press(input int pos);
        keys_down = 16'h1 << pos;
        wait_frames(5);
        keys_down = 16'h0;
        wait_frames(5);
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        repeat (3) @(posedge CLK);
        #1 CLR = 1'b1;
        repeat (FRAME + 6) @(posedge CLK);
        #3 CLR = 1'b0;
        #1;
        chk_cnt++;
        if (COLS !== 4'b1110) $display("FAIL rst_cols got=%b exp=1110", COLS); else pass_cnt++;
        chk_cnt++;
        if (BCD !== 16'h0000) $display("FAIL rst_bcd got=%h exp=0000", BCD); else pass_cnt++;
        chk_cnt++;
        if (VALID !== 1'b0 || KEY_STROBE !== 1'b0)
            $display("FAIL rst_pulses got=%b%b exp=00", VALID, KEY_STROBE);
        else pass_cnt++;
        @(negedge CLK);
        CLR = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge CLK);
            #1;
            if (i == 3) begin
                chk_cnt++;
                if (COLS !== 4'b1110) $display("FAIL scan_c0 got=%b exp=1110", COLS); else pass_cnt++;
            end
            if (i == 4) begin
                chk_cnt++;
                if (COLS !== 4'b1101) $display("FAIL scan_c1 got=%b exp=1101", COLS); else pass_cnt++;
            end
            if (i == 8) begin
                chk_cnt++;
                if (COLS !== 4'b1011) $display("FAIL scan_c2 got=%b exp=1011", COLS); else pass_cnt++;
            end
            if (i == 12) begin
                chk_cnt++;
                if (COLS !== 4'b0111) $display("FAIL scan_c3 got=%b exp=0111", COLS); else pass_cnt++;
            end
        end
        wait_frames(2);
    endtask

    task automatic test_digits();
        int s0;
        s0 = strobe_cnt;
        press(P_1);
        chk_cnt++;
        if (BCD !== 16'h0001) $display("FAIL dig1 got=%h exp=0001", BCD); else pass_cnt++;
        press(P_2);
        chk_cnt++;
        if (BCD !== 16'h0012) $display("FAIL dig12 got=%h exp=0012", BCD); else pass_cnt++;
        press(P_7);
        chk_cnt++;
        if (BCD !== 16'h0127) $display("FAIL dig127 got=%h exp=0127", BCD); else pass_cnt++;
        chk_cnt++;
        if (valid_cnt !== 0) $display("FAIL no_early_valid got=%0d exp=0", valid_cnt); else pass_cnt++;
        press(P_H);
        chk_cnt++;
        if (valid_cnt !== 1) $display("FAIL enter_valid got=%0d exp=1", valid_cnt); else pass_cnt++;
        chk_cnt++;
        if (valid_bcd !== 16'h0127) $display("FAIL enter_bcd got=%h exp=0127", valid_bcd); else pass_cnt++;
        chk_cnt++;
        if (BCD !== 16'h0127) $display("FAIL enter_hold got=%h exp=0127", BCD); else pass_cnt++;
        chk_cnt++;
        if (strobe_cnt - s0 !== 4) $display("FAIL dig_strobes got=%0d exp=4", strobe_cnt - s0); else pass_cnt++;
    endtask

    task automatic test_edit();
        int s0;
        press(P_9);
        chk_cnt++;
        if (BCD !== 16'h0009) $display("FAIL new_after_done got=%h exp=0009", BCD); else pass_cnt++;
        press(P_9);
        press(P_9);
        s0 = strobe_cnt;
        press(P_5);
        chk_cnt++;
        if (BCD !== 16'h0999) $display("FAIL overflow got=%h exp=0999", BCD); else pass_cnt++;
        chk_cnt++;
        if (strobe_cnt - s0 !== 1) $display("FAIL overflow_strobe got=%0d exp=1", strobe_cnt - s0); else pass_cnt++;
        press(P_S);
        chk_cnt++;
        if (BCD !== 16'h0099) $display("FAIL backspace got=%h exp=0099", BCD); else pass_cnt++;
        press(P_A);
        chk_cnt++;
        if (BCD !== 16'h1099) $display("FAIL sign got=%h exp=1099", BCD); else pass_cnt++;
        press(P_C);
        chk_cnt++;
        if (BCD !== 16'h0000) $display("FAIL clear got=%h exp=0000", BCD); else pass_cnt++;
        s0 = strobe_cnt;
        press(P_S);
        chk_cnt++;
        if (BCD !== 16'h0000) $display("FAIL bs_empty got=%h exp=0000", BCD); else pass_cnt++;
        chk_cnt++;
        if (strobe_cnt - s0 !== 1) $display("FAIL bs_empty_strobe got=%0d exp=1", strobe_cnt - s0); else pass_cnt++;
        s0 = strobe_cnt;
        press(P_B);
        press(P_D);
        chk_cnt++;
        if (BCD !== 16'h0000 || strobe_cnt - s0 !== 2)
            $display("FAIL bd_keys got=%h/%0d exp=0000/2", BCD, strobe_cnt - s0);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        int s0;
        s0 = strobe_cnt;
        keys_down = 16'h1 << P_5;
        wait_frames(2);
        keys_down = 16'h0;
        wait_frames(5);
        chk_cnt++;
        if (strobe_cnt - s0 !== 0) $display("FAIL glitch got=%0d exp=0", strobe_cnt - s0); else pass_cnt++;
        keys_down = 16'h1 << P_5;
        wait_frames(50);
        keys_down = 16'h0;
        wait_frames(5);
        chk_cnt++;
        if (strobe_cnt - s0 !== 1) $display("FAIL no_repeat got=%0d exp=1", strobe_cnt - s0); else pass_cnt++;
        chk_cnt++;
        if (BCD !== 16'h0005) $display("FAIL hold5 got=%h exp=0005", BCD); else pass_cnt++;
    endtask

    task automatic test_multi();
        int s0;
        s0 = strobe_cnt;
        keys_down = (16'h1 << P_3) | (16'h1 << P_6);
        wait_frames(5);
        keys_down = 16'h0;
        wait_frames(5);
        chk_cnt++;
        if (strobe_cnt - s0 !== 0 || BCD !== 16'h0005)
            $display("FAIL multi got=%0d/%h exp=0/0005", strobe_cnt - s0, BCD);
        else pass_cnt++;
        keys_down = 16'h1 << P_4;
        wait_frames(5);
        keys_down = (16'h1 << P_4) | (16'h1 << P_8);
        wait_frames(5);
        keys_down = 16'h1 << P_4;
        wait_frames(5);
        chk_cnt++;
        if (strobe_cnt - s0 !== 1) $display("FAIL multi_hold got=%0d exp=1", strobe_cnt - s0); else pass_cnt++;
        keys_down = 16'h0;
        wait_frames(5);
        chk_cnt++;
        if (BCD !== 16'h0054) $display("FAIL multi_digit got=%h exp=0054", BCD); else pass_cnt++;
        press(P_9);
        chk_cnt++;
        if (BCD !== 16'h0549 || strobe_cnt - s0 !== 2)
            $display("FAIL after_release got=%h/%0d exp=0549/2", BCD, strobe_cnt - s0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int s0;
        int v0;
        press(P_C);
        press(P_0);
        press(P_4);
        press(P_2);
        press(P_A);
        v0 = valid_cnt;
        press(P_H);
        chk_cnt++;
        if (valid_cnt - v0 !== 1 || valid_bcd !== 16'h1042)
            $display("FAIL enter_neg got=%0d/%h exp=1/1042", valid_cnt - v0, valid_bcd);
        else pass_cnt++;
        press(P_7);
        chk_cnt++;
        if (BCD !== 16'h0007) $display("FAIL restart got=%h exp=0007", BCD); else pass_cnt++;
        press(P_C);
        s0 = strobe_cnt;
        keys_down = 16'h1 << P_7;
        wait_frames(5);
        chk_cnt++;
        if (BCD !== 16'h0007) $display("FAIL held7 got=%h exp=0007", BCD); else pass_cnt++;
        CLR = 1'b0;
        #1;
        chk_cnt++;
        if (BCD !== 16'h0000) $display("FAIL mid_clr got=%h exp=0000", BCD); else pass_cnt++;
        repeat (3) @(posedge CLK);
        #1 CLR = 1'b1;
        wait_frames(6);
        chk_cnt++;
        if (BCD !== 16'h0007 || strobe_cnt - s0 !== 2)
            $display("FAIL reaccept got=%h/%0d exp=0007/2", BCD, strobe_cnt - s0);
        else pass_cnt++;
        wait_frames(5);
        keys_down = 16'h0;
        wait_frames(5);
        chk_cnt++;
        if (strobe_cnt - s0 !== 2) $display("FAIL single_reaccept got=%0d exp=2", strobe_cnt - s0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_digits();
        test_edit();
        test_bounce();
        test_multi();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/keypad_bcd_entry.md
# keypad_bcd_entry

Scans the DE10-Lite 4x4 matrix keypad, debounces key presses, and assembles a signed three-digit BCD entry for `BCD2BinarySM` in the input unit. Digit, sign, clear, backspace and enter keys edit a 16-bit sign+BCD word, and an enter key raises a one-cycle `VALID` strobe. The block replaces the bare keypad front end as the first stage of the input unit (IU).

## Interface
- `SCAN_DIV`, 50000: CLK cycles each column is driven (1 ms at 50 MHz); must be ≥ 4.
- `DEBOUNCE`, 20: consecutive identical full scan frames before a key state is accepted; must be ≥ 1.

- `CLK`  in  1  system clock, rising edge.
- `CLR`  in  1  asynchronous active-low reset.
- `ROWS`  in  4  keypad rows, active-low with external pull-ups; asynchronous to CLK.
- `COLS`  out  4  keypad column drive, active-low, exactly one bit low at a time.
- `BCD`  out  16  `[15:12]` sign nibble (4'h0 = +, 4'h1 = −); `[11:8]` hundreds, `[7:4]` tens, `[3:0]` units.
- `VALID`  out  1  one-cycle pulse, asserted when enter is accepted.
- `KEY_STROBE`  out  1  one-cycle pulse, asserted on every accepted key press.

## Operation
- Key map, row-major from row 0, col 0: `1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D`.
- Scan:
  - Column index cycles 0→1→2→3→0, advancing every `SCAN_DIV` cycles.
  - `COLS = ~(4'b0001 << idx)`.
  - `ROWS` is passed through a 2-flop synchronizer.
  - Rows are sampled on the last cycle of each column slot.
- Frame code: after column 3 is sampled, the frame is classified as NONE, MULTI (two or more keys down), or a single key code 0–15.
- Debounce: the stable code updates only after the same frame code is seen in `DEBOUNCE` consecutive frames.
- Key FSM:
  - IDLE → PRESSED when the stable code becomes a single key. This is the press event; `KEY_STROBE` pulses.
  - PRESSED → IDLE only when the stable code becomes NONE.
  - MULTI in either state never produces a press. There is no auto-repeat.
- Entry actions, applied on a press event. `n` = digits entered (0–3). `done` is set by enter.
  - **Digit 0–9:**
    - If `done`: clear digits, set sign to +, clear `done`, then proceed.
    - If `n < 3`: shift left (hundreds←tens, tens←units, units←key) and increment `n`.
    - If `n = 3`: ignore the key.
  - **A:** toggle the sign; clears `done`.
  - **C:** set digits to 0, sign to +, `n` to 0, `done` to 0.
  - **\*:** backspace. If `n > 0`: shift right (units←tens, tens←hundreds, hundreds←0) and decrement `n`. If `n = 0`: no-op.
  - **#:** pulse `VALID` and set `done`. `BCD` is held unchanged.
  - **B, D:** `KEY_STROBE` pulses; no other effect.
- No range check is made here; 999 is legal output, and range is checked downstream.

## Timing
- Reset values: `COLS = 4'b1110`, `BCD = 16'h0000`, `VALID = 0`, `KEY_STROBE = 0`. Column counter, debounce counter, FSM (IDLE), `n` and `done` are all cleared.
- `CLR` assertion mid-scan or mid-press clears everything immediately. A key still held at release of `CLR` is accepted once, after `DEBOUNCE` frames.
- Press latency, from key closure stable on `ROWS` to `KEY_STROBE`: 2 sync cycles + remainder of current frame + `DEBOUNCE` frames. One frame = `4*SCAN_DIV` cycles.
- `KEY_STROBE`, the `BCD` update and `VALID` all occur in the same cycle, on the clock edge after the press event is detected.
- `BCD` is registered and changes only on press events or reset.
- Key released then pressed again within a frame: no event. It is filtered by debounce.
- Second key added while PRESSED: frame goes MULTI, no event. When the frame returns to the original single key, still no event; a return to NONE is required.

## Structure
- Shared package `keypad_pkg`:
  - Key code localparams: `KEY_0`..`KEY_9`, `KEY_A`, `KEY_B`, `KEY_C`, `KEY_D`, `KEY_STAR`, `KEY_HASH`.
  - Frame code encodings: NONE, MULTI.
  - Sign nibbles: `SIGN_POS = 4'h0`, `SIGN_NEG = 4'h1`.
  - FSM state encodings.
- Sub-module `keypad_scanner` (parameters `SCAN_DIV`, `DEBOUNCE`):
  - Contains the column drive, synchronizer, frame classifier, debounce and key FSM.
  - Outputs `key_code[3:0]` and a `press` pulse.
- The top level holds the entry register, `n`, `done` and the action decoder.

## Test plan
Bench uses `SCAN_DIV = 4`, `DEBOUNCE = 3`. Each press holds the key for 5 frames, then releases it for 5 frames.

1. **Reset:** assert `CLR` low mid-scan → `COLS = 1110`, `BCD = 0000`, `VALID = 0`. After release, `COLS` steps 1101, 1011, 0111 every 4 cycles.
2. **Digit entry:** press 1, 2, 7, # → `BCD` reads 0001, 0012, 0127. `VALID` pulses once at #, with `BCD = 16'h0127`.
3. **Overflow, backspace, sign:** press 9, 9, 9, 5 → `BCD = 0999`. Press \* → 0099. Press A → 1099. Press C → 0000. Press \* on empty → no change, `KEY_STROBE` still pulses.
4. **Bounce and auto-repeat:** glitch key 5 for 2 frames → no `KEY_STROBE`. Hold key 5 for 50 frames → exactly one `KEY_STROBE`, `BCD = 0005`.
5. **Multi-key:** press 3 and 6 together → no event. While 4 is held, add 8, then release 8 → one event only (digit 4). A new press is accepted only after full release.
6. **New entry after enter:** after `VALID` with `BCD = 1042`, press 7 → `BCD = 0007`. Mid-hold `CLR` pulse → `BCD = 0000`, then one press is accepted if the key is still held.
